rca_pipe: RTL and testbench
===========================

// Module: rca_pipe
// PURPOSE
//   Parametrised, pipelined ripple-carry adder/subtractor; successor to the 8-bit combinational RCA.
//   Splits a WIDTH-bit add into STAGES ripple segments, with the carry registered between segments.
//   Valid/ready handshake on both sides: sustains one operation per clock with fixed latency.
//   Used wherever wide add/sub must close timing in the datapath.
// PARAMETERS
//   WIDTH   32  operand/sum width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline segments (>=1); each segment is a SEG=WIDTH/STAGES-bit ripple chain
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block accepts operands this cycle
//   x_in       in   WIDTH  operand A
//   y_in       in   WIDTH  operand B
//   c_in       in   1      carry-in (add) / borrow-in (sub)
//   sub_in     in   1      0: A+B+c_in ; 1: A-B-c_in
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result this cycle
//   sum        out  WIDTH  result
//   cout       out  1      carry-out (add); NOT borrow (sub): 1 = no borrow
//   ovf        out  1      signed two's-complement overflow
// BEHAVIOUR
//   - Operand preparation at acceptance:
//     - add: B' = y_in, cin' = c_in.
//     - sub: B' = ~y_in, cin' = ~c_in, so the result is A + ~B + ~c_in = A - B - c_in mod 2^WIDTH.
//   - Acceptance: in_valid && in_ready. Completion: out_valid && out_ready.
//   - Global advance enable en = out_ready || !out_valid; in_ready = en (combinational).
//   - When en=0, every pipeline register holds its value. No data loss, no duplication.
//   - Stage k (0..STAGES-1):
//     - Adds slice [k*SEG +: SEG] of A and B' plus the carry registered by stage k-1.
//     - Stage 0 uses cin'.
//     - Upper operand slices travel skewed through delay registers.
//     - Completed lower sum slices travel deskewed, so all slices of one operation exit together.
//   - A valid bit travels with each operation; bubbles (in_valid=0) propagate as invalid slots.
//   - Latency: result is presented on sum/cout/ovf with out_valid=1 exactly STAGES cycles after
//     acceptance, provided en stays 1. Each cycle with en=0 adds one cycle.
//     STAGES=1 gives a single register stage (latency 1).
//   - Throughput: one operation per cycle while out_ready=1.
//   - cout = carry out of bit WIDTH-1.
//   - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
//   - Results are unsigned/signed agnostic mod 2^WIDTH; ordering is strictly FIFO.
//   - Output registers (sum, cout, ovf, out_valid) hold while out_valid && !out_ready.
//   - Reset (async assert, any time including mid-operation):
//     - All valid bits are 0, out_valid=0, sum=0, cout=0, ovf=0. In-flight operations are discarded.
//     - in_ready=1 immediately after reset, since out_valid=0.
//   - Simultaneous accept and complete in one cycle is legal and is the normal streaming case.
//   - Operand/control inputs are ignored when in_valid=0 or in_ready=0.
// TESTING  (WIDTH=32, STAGES=4)
//   1. Full carry ripple: x=FFFFFFFF, y=00000001, c_in=0, add
//      -> sum=00000000, cout=1, ovf=0; out_valid 4 cycles after accept.
//   2. Subtract with borrow: x=00000005, y=00000007, c_in=0, sub
//      -> sum=FFFFFFFE, cout=0. Then x=7, y=5, c_in=1 -> sum=00000001, cout=1.
//   3. Signed overflow: 7FFFFFFF+00000001 -> sum=80000000, ovf=1, cout=0.
//      80000000-00000001 (sub) -> 7FFFFFFF, ovf=1.
//   4. Backpressure: stream 8 random ops back-to-back, out_ready=0 for cycles 5-7
//      -> in_ready=0 exactly while stalled; all 8 results match the model in order, none dropped or repeated.
//   5. Bubbles/throughput: alternate in_valid=1/0 with out_ready=1
//      -> out_valid pattern mirrors input delayed by 4 cycles.
//      Then continuous in_valid -> one result per cycle.
//   6. Reset mid-flight: assert rst_n=0 with 3 ops in the pipe
//      -> out_valid, sum, cout, ovf = 0 asynchronously; after release, no stale result ever appears.

Source files
------------

// File: rtl/rca_pipe_if.sv
// Valid/ready operand and result bundle for the pipelined adder/subtractor.
// Ports: in_valid/in_ready/x_in/y_in/c_in/sub_in (operand side), out_valid/out_ready/sum/cout/ovf (result side).
// master = producer/consumer (drives operands, accepts results); slave = the adder itself.
interface rca_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             c_in;
  logic             sub_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x_in, y_in, c_in, sub_in, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, x_in, y_in, c_in, sub_in, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry add/sub: WIDTH bits split into STAGES ripple segments, carry registered between them.
// Latency STAGES cycles from acceptance to out_valid; one op per cycle. Ports: clk, rst_n, bus (rca_pipe_if.slave).
// Backpressure: a single enable (out_ready || !out_valid) freezes every stage; in_ready mirrors it combinationally.
module rca_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic       clk,
  input logic       rst_n,
  rca_pipe_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  // Per-stage registers. Stage k holds the operation after segment k has been added:
  // a_q/b_q carry the (not yet consumed) operand bits forward, s_q accumulates completed
  // sum slices, c_q is the carry out of segment k, m_q the carry into the segment's top bit.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             m_q [STAGES];

  // Inputs seen by each segment's adder.
  logic             v_d [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];

  // Segment adder results.
  logic [WIDTH-1:0] s_n [STAGES];
  logic             c_n [STAGES];
  logic             m_n [STAGES];

  logic en;

  assign en           = bus.out_ready || !v_q[STAGES-1];
  assign bus.in_ready = en;

  // Stage 0 takes the live operands; subtraction is folded in here as A + ~B + ~c_in.
  always_comb begin
    v_d[0] = bus.in_valid;
    a_d[0] = bus.x_in;
    b_d[0] = bus.sub_in ? ~bus.y_in : bus.y_in;
    c_d[0] = bus.sub_in ^ bus.c_in;
    s_d[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      c_d[k] = c_q[k-1];
      s_d[k] = s_q[k-1];
    end
  end

  // One SEG-bit ripple chain per stage, working on slice k of the skewed operands.
  always_comb begin
    logic carry;
    logic ta;
    logic tb;
    carry = 1'b0;
    ta    = 1'b0;
    tb    = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      carry  = c_d[k];
      s_n[k] = s_d[k];
      m_n[k] = 1'b0;
      for (int i = 0; i < SEG; i++) begin
        ta = a_d[k][k*SEG+i];
        tb = b_d[k][k*SEG+i];
        // Last iteration leaves the carry into the segment's top bit, used for overflow.
        m_n[k] = carry;
        s_n[k][k*SEG+i] = ta ^ tb ^ carry;
        carry = (ta & tb) | (carry & (ta ^ tb));
      end
      c_n[k] = carry;
    end
  end

  // Data registers only load on valid slots so the output holds its last result across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_n[k];
          c_q[k] <= c_n[k];
          m_q[k] <= m_n[k];
        end
      end
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = c_q[STAGES-1] ^ m_q[STAGES-1];
endmodule

// File: tb/tb_rca_pipe.sv
// Bench for rca_pipe (WIDTH=32, STAGES=4): directed vector table plus streaming sequences.
// Latency measured per vector; stall, bubble, throughput and mid-flight reset sequences use a scoreboard.
// Inputs driven on the falling edge, outputs sampled 1ns later.
module tb_rca_pipe;
  logic clk;
  logic rst_n;

  rca_pipe_if #(.WIDTH(32)) bus ();

  rca_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
    $fatal(1);
  end

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        c;
    logic        s;
    logic [31:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t vecs [12];

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] op_x [64];
  logic [31:0] op_y [64];
  logic        op_c [64];
  logic        op_s [64];
  int          sent = 0;
  int          rcv  = 0;
  logic [33:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: plain 33-bit addition, signed overflow from operand/result signs.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic s);
    logic [32:0] r;
    logic [31:0] b;
    logic        ci;
    logic        ov;
    b  = s ? ~y : y;
    ci = s ? ~c : c;
    r  = {1'b0, x} + {1'b0, b} + {32'b0, ci};
    ov = (x[31] == b[31]) && (r[31] != x[31]);
    return {r[32], ov, r[31:0]};
  endfunction

  // One vector in an otherwise empty pipe; measure cycles to out_valid.
  task automatic run_one(input int idx, input vec_t v);
    int   cnt;
    logic got;
    bus.x_in     = v.x;
    bus.y_in     = v.y;
    bus.c_in     = v.c;
    bus.sub_in   = v.s;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", idx), bus.in_ready, 1);
    cnt = 0;
    got = 1'b0;
    while (cnt < 20 && !got) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      cnt++;
      #1;
      if (bus.out_valid) got = 1'b1;
    end
    chk($sformatf("v%0d_latency", idx), cnt, 4);
    chk($sformatf("v%0d_sum", idx), bus.sum, v.es);
    chk($sformatf("v%0d_cout", idx), bus.cout, v.ec);
    chk($sformatf("v%0d_ovf", idx), bus.ovf, v.eo);
    @(negedge clk);
  endtask

  // One cycle of streaming: drive, sample, score completions/acceptances, advance to next falling edge.
  task automatic step(input logic v, input logic r, output logic ov, output logic ir);
    logic [33:0] e;
    bus.in_valid  = v;
    bus.x_in      = op_x[sent];
    bus.y_in      = op_y[sent];
    bus.c_in      = op_c[sent];
    bus.sub_in    = op_s[sent];
    bus.out_ready = r;
    #1;
    ir = bus.in_ready;
    ov = bus.out_valid;
    if (ov && r) begin
      chk("result_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("res%0d", rcv), {30'b0, bus.cout, bus.ovf, bus.sum}, {30'b0, e});
      end
      rcv++;
    end
    if (v && ir) begin
      exp_q.push_back(model(op_x[sent], op_y[sent], op_c[sent], op_s[sent]));
      sent++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic ov;
    logic ir;
    int   rcv0;
    int   stale;

    vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0};
    vecs[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
    vecs[6]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
    vecs[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[8]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[10] = '{32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0, 32'h0001FFFF, 1'b0, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};

    for (int i = 0; i < 64; i++) begin
      op_x[i] = $urandom;
      op_y[i] = $urandom;
      op_c[i] = 1'($urandom_range(0, 1));
      op_s[i] = 1'($urandom_range(0, 1));
    end

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.c_in      = 1'b0;
    bus.sub_in    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, one at a time.
    for (int i = 0; i < 12; i++) run_one(i, vecs[i]);

    // Back-to-back stream with the consumer stalled in cycles 5..7.
    rcv0 = rcv;
    for (int t = 0; t < 40 && (rcv - rcv0) < 8; t++) begin
      step((sent < 8 + 0) || (t < 8 && (sent - 0) < 8), !(t >= 5 && t <= 7), ov, ir);
      if (t < 12) chk($sformatf("bp_in_ready_t%0d", t), ir, (t >= 5 && t <= 7) ? 0 : 1);
    end
    chk("bp_result_count", rcv - rcv0, 8);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Alternating bubbles: out_valid mirrors in_valid 4 cycles later.
    for (int t = 0; t < 16; t++) begin
      step(t < 10 && (t % 2) == 0, 1'b1, ov, ir);
      chk($sformatf("bub_out_valid_t%0d", t), ov, (t >= 4 && t < 14 && ((t - 4) % 2) == 0) ? 1 : 0);
    end

    // Continuous input: one result per cycle.
    for (int t = 0; t < 14; t++) begin
      step(t < 8, 1'b1, ov, ir);
      chk($sformatf("thr_out_valid_t%0d", t), ov, (t >= 4 && t < 12) ? 1 : 0);
    end
    chk("thr_queue_empty", exp_q.size(), 0);

    // Reset with operations in flight and a result held at the output.
    op_x[sent] = 32'h80000000;
    op_y[sent] = 32'hFFFFFFFF;
    op_c[sent] = 1'b0;
    op_s[sent] = 1'b0;
    for (int t = 0; t < 4; t++) step(1'b1, 1'b1, ov, ir);
    step(1'b0, 1'b0, ov, ir);
    chk("rmf_pre_out_valid", ov, 1);
    #1;
    chk("rmf_pre_sum", bus.sum, 32'h7FFFFFFF);
    chk("rmf_pre_cout", bus.cout, 1);
    chk("rmf_pre_ovf", bus.ovf, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmf_out_valid", bus.out_valid, 0);
    chk("rmf_sum", bus.sum, 0);
    chk("rmf_cout", bus.cout, 0);
    chk("rmf_ovf", bus.ovf, 0);
    chk("rmf_in_ready", bus.in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int t = 0; t < 12; t++) begin
      step(1'b0, 1'b1, ov, ir);
      if (ov) stale++;
    end
    chk("rmf_stale_results", stale, 0);

    // Pipe still works after reset.
    run_one(99, vecs[3]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
